// File: rtl/sequence_player_if.sv
// Store bus shared between the CPU and bus initiators such as sequence_player.
// Handshake: the master holds wren/address_dmem/data stable while wren=1; a store completes on any rising edge where wren && bus_gnt.
interface sequence_player_if;
  logic        wren;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        bus_gnt;

  modport master (output wren, output address_dmem, output data, input bus_gnt);
  modport slave  (input wren, input address_dmem, input data, output bus_gnt);
endinterface

// File: rtl/sequence_player.sv
// Plays a stored Simon colour sequence as LED (addr 6) and tone (addr 8) stores on the shared store bus.
// Optional feature macro: SEQ_AUDIO_EN enables the tone stores; when undefined only LED stores are issued.
module sequence_player #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int DEPTH      = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     seq_we,
  input  logic [$clog2(DEPTH)-1:0] seq_addr,
  input  logic [1:0]               seq_color,
  input  logic [$clog2(DEPTH):0]   seq_len,
  input  logic                     start,
  sequence_player_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               state_dbg
);

  localparam int AW       = $clog2(DEPTH);
  localparam int MAXC     = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW       = $clog2(MAXC + 1);
  localparam int ON_LAST  = (ON_CYCLES  > 0) ? ON_CYCLES  - 1 : 0;
  localparam int OFF_LAST = (OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LED_ON  = 3'd1,
    S_AUD_ON  = 3'd2,
    S_HOLD    = 3'd3,
    S_LED_OFF = 3'd4,
    S_AUD_OFF = 3'd5,
    S_GAP     = 3'd6,
    S_FIN     = 3'd7
  } state_t;

  state_t          state, state_n;
  logic [AW:0]     len_q;
  logic [AW:0]     idx_q;
  logic [AW:0]     idx_inc;
  logic [1:0]      color_q;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      mem [DEPTH];

  logic            start_play;
  logic            step_next;
  logic [AW-1:0]   rd_idx;
  logic [AW:0]     len_clamped;
  logic            wren_c;
  logic [11:0]     addr_c;
  logic [31:0]     data_c;

  assign idx_inc     = idx_q + (AW+1)'(1);
  assign len_clamped = (seq_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : seq_len;
  assign rd_idx      = start_play ? '0 : idx_inc[AW-1:0];
  assign state_dbg   = state;

  assign bus.wren         = wren_c;
  assign bus.address_dmem = addr_c;
  assign bus.data         = data_c;

  always_ff @(posedge clock) begin
    if (seq_we) mem[seq_addr] <= seq_color;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    wren_c     = 1'b0;
    addr_c     = 12'd0;
    data_c     = 32'd0;
    busy       = (state != S_IDLE) && (state != S_FIN);
    done       = 1'b0;
    start_play = 1'b0;
    step_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (seq_len == '0) begin
            state_n = S_FIN;
          end else begin
            state_n    = S_LED_ON;
            start_play = 1'b1;
          end
        end
      end
      S_LED_ON: begin
        wren_c = 1'b1;
        addr_c = 12'd6;
        data_c = {29'd0, color_q, 1'b1};
        if (bus.bus_gnt) begin
`ifdef SEQ_AUDIO_EN
          state_n = S_AUD_ON;
`else
          state_n = S_HOLD;
`endif
        end
      end
      S_AUD_ON: begin
        wren_c = 1'b1;
        addr_c = 12'd8;
        data_c = {29'd0, color_q, 1'b1};
        if (bus.bus_gnt) state_n = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == CW'(ON_LAST)) state_n = S_LED_OFF;
      end
      S_LED_OFF: begin
        wren_c = 1'b1;
        addr_c = 12'd6;
        data_c = {29'd0, color_q, 1'b0};
        if (bus.bus_gnt) begin
`ifdef SEQ_AUDIO_EN
          state_n = S_AUD_OFF;
`else
          state_n = S_GAP;
`endif
        end
      end
      S_AUD_OFF: begin
        wren_c = 1'b1;
        addr_c = 12'd8;
        data_c = {29'd0, color_q, 1'b0};
        if (bus.bus_gnt) state_n = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == CW'(OFF_LAST)) begin
          if (idx_inc == len_q) begin
            state_n = S_FIN;
          end else begin
            state_n   = S_LED_ON;
            step_next = 1'b1;
          end
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The counter restarts on every state change, so each HOLD/GAP entry begins at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_n != state) begin
      cnt_q <= '0;
    end else if ((state == S_HOLD) || (state == S_GAP)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Colour is captured when entering LED_ON; a same-cycle write to that entry is forwarded.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q   <= '0;
      idx_q   <= '0;
      color_q <= '0;
    end else begin
      if (start_play) begin
        len_q <= len_clamped;
        idx_q <= '0;
      end else if (step_next) begin
        idx_q <= idx_inc;
      end
      if (start_play || step_next) begin
        if (seq_we && (seq_addr == rd_idx)) color_q <= seq_color;
        else                                color_q <= mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with ON_CYCLES=4, OFF_CYCLES=2; expectations follow SEQ_AUDIO_EN.
module tb_sequence_player;

  localparam int ON  = 4;
  localparam int OFF = 2;
`ifdef SEQ_AUDIO_EN
  localparam int STEP = 4 + ON + OFF;
`else
  localparam int STEP = 2 + ON + OFF;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       seq_we;
  logic [4:0] seq_addr;
  logic [1:0] seq_color;
  logic [5:0] seq_len;
  logic       start;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  sequence_player_if bus();

  sequence_player #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .DEPTH(32)) dut (
    .clock(clock), .reset(reset), .seq_we(seq_we), .seq_addr(seq_addr),
    .seq_color(seq_color), .seq_len(seq_len), .start(start), .bus(bus),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_wren_cyc = 0;
  int wren_cycles = 0;
  bit seen_wren = 0;
  int d0;
  int n;
  logic [43:0] exp_q[$];
  logic [43:0] obs_q[$];

  always @(posedge clock) cyc++;

  // Bus monitor: records every completed store and each done pulse.
  always @(negedge clock) begin
    if (bus.wren) begin
      wren_cycles++;
      if (!seen_wren) begin
        seen_wren = 1;
        first_wren_cyc = cyc;
      end
      if (bus.bus_gnt) obs_q.push_back({bus.address_dmem, bus.data});
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_trk();
    obs_q.delete();
    exp_q.delete();
    seen_wren = 0;
    wren_cycles = 0;
  endtask

  task automatic push_step(input logic [1:0] c);
    exp_q.push_back({12'd6, 29'd0, c, 1'b1});
`ifdef SEQ_AUDIO_EN
    exp_q.push_back({12'd8, 29'd0, c, 1'b1});
`endif
    exp_q.push_back({12'd6, 29'd0, c, 1'b0});
`ifdef SEQ_AUDIO_EN
    exp_q.push_back({12'd8, 29'd0, c, 1'b0});
`endif
  endtask

  task automatic compare_stores(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_store%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic write_entry(input logic [4:0] a, input logic [1:0] c);
    seq_we = 1; seq_addr = a; seq_color = c;
    @(posedge clock); #1;
    seq_we = 0;
  endtask

  task automatic pulse_start(input logic [5:0] len);
    seq_len = len; start = 1;
    @(posedge clock); #1;
    start = 0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clock);
      k++;
    end
    #1;
    check({tag, "_done_seen"}, done_cnt >= target, 1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int k = 0;
    while (state_dbg !== s && k < 100) begin
      @(posedge clock); #1;
      k++;
    end
    check({tag, "_reached"}, state_dbg, s);
  endtask

  initial begin
    reset = 1; seq_we = 0; seq_addr = 0; seq_color = 0; seq_len = 0; start = 0;
    bus.bus_gnt = 1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_wren", bus.wren, 0);
    check("rst_addr", bus.address_dmem, 0);
    check("rst_data", bus.data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    reset = 0;
    @(posedge clock); #1;

    // Single step, entry written in the same cycle as start.
    clear_trk(); d0 = done_cnt;
    seq_we = 1; seq_addr = 0; seq_color = 2'b10; seq_len = 1; start = 1;
    @(posedge clock); #1;
    seq_we = 0; start = 0;
    check("s1_wren", bus.wren, 1);
    check("s1_addr", bus.address_dmem, 6);
    check("s1_data", bus.data, 32'h5);
    check("s1_busy", busy, 1);
    wait_done(d0 + 1, 200, "s1");
    push_step(2'b10);
    compare_stores("s1");
    check("s1_duration", done_cyc - first_wren_cyc, STEP);
    check("s1_done_once", done_cnt, d0 + 1);
    check("s1_busy_after", busy, 0);

    // Three steps; overwrite entry0 while it plays, and a start while busy.
    write_entry(0, 2'b00); write_entry(1, 2'b01); write_entry(2, 2'b11);
    clear_trk(); d0 = done_cnt;
    seq_len = 3; start = 1;
    @(posedge clock); #1;
    start = 0; seq_we = 1; seq_addr = 0; seq_color = 2'b11;
    @(posedge clock); #1;
    seq_we = 0;
    repeat (10) @(posedge clock);
    #1;
    pulse_start(1);
    check("s2_busy_mid", busy, 1);
    wait_done(d0 + 1, 400, "s2");
    push_step(2'b00); push_step(2'b01); push_step(2'b11);
    compare_stores("s2");
    check("s2_duration", done_cyc - first_wren_cyc, 3 * STEP);
    check("s2_done_once", done_cnt, d0 + 1);

    // Grant withheld for 5 cycles during LED_OFF.
    write_entry(0, 2'b10);
    clear_trk(); d0 = done_cnt;
    pulse_start(1);
    wait_state(3'd4, "s3_led_off");
    bus.bus_gnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("s3_wren%0d", i), bus.wren, 1);
      check($sformatf("s3_addr%0d", i), bus.address_dmem, 6);
      check($sformatf("s3_data%0d", i), bus.data, 32'h4);
      @(posedge clock); #1;
    end
    check("s3_still_stalled", state_dbg, 4);
    bus.bus_gnt = 1;
    @(posedge clock); #1;
`ifdef SEQ_AUDIO_EN
    check("s3_advanced", state_dbg, 5);
`else
    check("s3_advanced", state_dbg, 6);
`endif
    wait_done(d0 + 1, 200, "s3");
    push_step(2'b10);
    compare_stores("s3");
    check("s3_duration", done_cyc - first_wren_cyc, STEP + 5);

    // Zero length: done next cycle, no stores.
    clear_trk(); d0 = done_cnt;
    pulse_start(0);
    check("s4_done", done, 1);
    check("s4_busy", busy, 0);
    check("s4_wren", bus.wren, 0);
    @(posedge clock); #1;
    check("s4_done_low", done, 0);
    check("s4_no_wren", wren_cycles, 0);
    check("s4_done_once", done_cnt, d0 + 1);

    // Reset during the second step's HOLD, then replay from step 0.
    write_entry(0, 2'b01); write_entry(1, 2'b11);
    clear_trk();
    pulse_start(3);
    wait_state(3'd3, "s5_hold0");
    wait_state(3'd4, "s5_off0");
    wait_state(3'd3, "s5_hold1");
    reset = 1;
    #1;
    check("s5_rst_wren", bus.wren, 0);
    check("s5_rst_addr", bus.address_dmem, 0);
    check("s5_rst_data", bus.data, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_done", done, 0);
    check("s5_rst_state", state_dbg, 0);
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
    clear_trk(); d0 = done_cnt;
    pulse_start(1);
    check("s5_replay_addr", bus.address_dmem, 6);
    check("s5_replay_data", bus.data, 32'h3);
    wait_done(d0 + 1, 200, "s5");
    push_step(2'b01);
    compare_stores("s5");

    // Length above DEPTH clamps to 32 steps.
    clear_trk(); d0 = done_cnt;
    pulse_start(40);
    wait_done(d0 + 1, 32 * STEP + 50, "s6");
    check("s6_duration", done_cyc - first_wren_cyc, 32 * STEP);
    n = 0;
    foreach (obs_q[i]) if (obs_q[i][43:32] == 12'd6 && obs_q[i][0]) n++;
    check("s6_led_on_count", n, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_player.md
# sequence_player

Hardware bus initiator that plays a stored Simon colour sequence by issuing memory-mapped stores on the same store interface the processor uses for its peripherals. For each step it writes the LED-flash word to address 6, optionally writes the tone word to address 8, holds for a programmable on-time, then writes the matching off words and waits a gap. It sits beside the CPU on the data-memory store path. A bus grant handshake lets the top level arbitrate the shared `wren`/address/data lines.

## Interface
- `ON_CYCLES`, default 25_000_000: clock cycles each colour stays lit/sounding (0.5 s at 50 MHz).
- `OFF_CYCLES`, default 12_500_000: clock cycles of silence between steps.
- `DEPTH`, default 32: sequence storage entries; must be a power of two.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `seq_we` in 1: write one sequence entry.
- `seq_addr` in log2(DEPTH): entry index for `seq_we`.
- `seq_color` in 2: colour code to store; 00 red, 01 blue, 10 green, 11 yellow.
- `seq_len` in log2(DEPTH)+1: number of steps to play; sampled at `start`.
- `start` in 1: single-cycle request to begin playback.
- `bus_gnt` in 1: arbiter grant; a store completes on a cycle with `wren && bus_gnt`.
- `wren` out 1: store request (doubles as bus request).
- `address_dmem` out 12: store address, 6 or 8.
- `data` out 32: store data; [2:1] colour, [0] on(1)/off(0), [31:3] zero.
- `busy` out 1: high from accepting `start` until `done`.
- `done` out 1: one-cycle pulse when playback finishes.

## Operation
- States: IDLE, LED_ON, AUD_ON, HOLD, LED_OFF, AUD_OFF, GAP, FIN.
- IDLE:
  - `start`=1 with `seq_len`≠0 → latch the length, set step index to 0, set `busy` → LED_ON.
  - `start`=1 with `seq_len`=0 → FIN directly; no stores are issued.
- LED_ON: `wren`=1, addr 6, data {29'b0, color, 1'b1}. Advance on grant → AUD_ON.
- AUD_ON: same word to addr 8. Advance on grant → HOLD.
- HOLD: count ON_CYCLES cycles → LED_OFF.
- LED_OFF: addr 6, data {color, 1'b0}. Advance on grant → AUD_OFF.
- AUD_OFF: addr 8, data {color, 1'b0}. Advance on grant → GAP.
- GAP: count OFF_CYCLES cycles, then increment the index.
  - Index = latched length → FIN.
  - Otherwise → LED_ON.
- FIN: `done`=1 and `busy`=0 for one cycle → IDLE.
- Without grant, the FSM stalls with `wren`, `address_dmem` and `data` held stable.
- `color` comes from the storage entry at the current index, read combinationally or registered. It must be valid in the first cycle of LED_ON.
- Storage is written with `seq_we` at any time. A write to the entry currently playing must not change the words already being issued for that step: latch the colour on entry to LED_ON.
- `start` while busy is ignored.
- A `seq_len` value greater than DEPTH is clamped to DEPTH.
- The cycle counter is wide enough for max(ON_CYCLES, OFF_CYCLES). It resets to 0 on every HOLD/GAP entry.

## Timing
- Reset values: `wren`=0, `address_dmem`=0, `data`=0, `busy`=0, `done`=0, state IDLE. Storage contents are not reset.
- Reset asserted mid-playback aborts immediately. An LED or tone may be left on; software clears it.
- `start` is sampled on a rising edge in IDLE. `wren` is high from the next cycle.
- With `bus_gnt` held high, each step lasts 4 + ON_CYCLES + OFF_CYCLES cycles.
- `done` rises exactly one cycle after the last GAP cycle.
- `busy` falls in the same cycle `done` is high.
- `seq_we` and `start` in the same cycle: the write lands, and playback reads the new value.

## Configuration
- `SEQ_AUDIO_EN` defined: AUD_ON and AUD_OFF are issued as described.
- `SEQ_AUDIO_EN` undefined: those states are skipped, so LED_ON→HOLD and LED_OFF→GAP. No address-8 store ever appears, and each step is 2 + ON_CYCLES + OFF_CYCLES cycles.

## Test plan
All scenarios use ON_CYCLES=4, OFF_CYCLES=2 and `SEQ_AUDIO_EN` defined unless stated.
- Single step: load entry0=10 (green), `seq_len`=1, `bus_gnt`=1, pulse `start`. Expect stores (6,0x5), (8,0x5), 4 idle cycles, (6,0x4), (8,0x4), 2 cycles, then `done`. Total 10 cycles from the first `wren` to `done`.
- Multi-step: entries {00,01,11}, `seq_len`=3. Expect address-6 on-data 0x1, 0x3, 0x7 in order, and `done` once after 30 cycles.
- Grant stall: drop `bus_gnt` for 5 cycles during LED_OFF. Expect `wren`=1 with addr 6 and data 0x4 stable throughout; completion one cycle after grant returns.
- Zero length / busy start: `seq_len`=0, then `start`. Expect `done` on the next cycle and no `wren`. A second `start` during a 3-step play changes nothing.
- Reset mid-play: assert `reset` in HOLD. Expect all outputs 0 at once; a later `start` replays from step 0.
- Build without `SEQ_AUDIO_EN`, single step. Expect no address-8 store and an 8-cycle step.
